// File: rtl/fetch_unit.sv
// Instruction fetch unit. It keeps at most one instruction-memory request
// outstanding, drives the PC register and fills the IF/ID pipeline register.
// When decode stalls, a single response is parked in a one-entry buffer.
// A redirect flushes IF/ID, and any response still in flight is dropped.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_REQ   | request at pc_i is presented, waiting for the grant
//   S_WAIT  | request granted, waiting for read data
//   S_HOLD  | response parked in the buffer while decode stalls
//   S_DRAIN | redirected while a request was outstanding; drop its data
module fetch_unit #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    output logic [31:0] pc_next_o,
    output logic        pc_write_en_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        ifid_valid_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;

    logic        req_raw;
    logic        we_raw;
    logic        cap_req;
    logic        cap_buf;
    logic        ld_mem;
    logic        ld_buf;
    logic [31:0] pc_aligned;

    assign pc_aligned  = {pc_i[31:2], 2'b00};
    assign imem_addr_o = pc_aligned;

    // Reset holds the request and the PC write low even though state is S_REQ,
    // so the first request goes out on the edge after reset is released.
    assign imem_req_o    = req_raw & rst_n;
    assign pc_write_en_o = we_raw & rst_n;

    // Next-state and control decode; a redirect overrides every state.
    always_comb begin
        state_d   = state_q;
        req_raw   = 1'b0;
        we_raw    = 1'b0;
        pc_next_o = pc_i + 32'd4;
        cap_req   = 1'b0;
        cap_buf   = 1'b0;
        ld_mem    = 1'b0;
        ld_buf    = 1'b0;

        if (redirect_i) begin
            we_raw    = 1'b1;
            pc_next_o = {redirect_pc_i[31:2], 2'b00};
        end

        case (state_q)
            S_REQ: begin
                if (!redirect_i) begin
                    req_raw = 1'b1;
                    if (imem_gnt_i) begin
                        we_raw  = 1'b1;
                        cap_req = 1'b1;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (redirect_i) begin
                    state_d = imem_rvalid_i ? S_REQ : S_DRAIN;
                end else if (imem_rvalid_i) begin
                    if (stall_i) begin
                        cap_buf = 1'b1;
                        state_d = S_HOLD;
                    end else begin
                        ld_mem  = 1'b1;
                        state_d = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_i) begin
                    state_d = S_REQ;
                end else if (!stall_i) begin
                    ld_buf  = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid_i) begin
                    state_d = S_REQ;
                end
            end
            default: state_d = S_REQ;
        endcase
    end

    // Request-PC latch, response buffer and IF/ID next values.
    always_comb begin
        req_pc_d     = req_pc_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;

        if (cap_req) begin
            req_pc_d = pc_aligned;
        end
        if (cap_buf) begin
            buf_pc_d    = req_pc_q;
            buf_instr_d = imem_rdata_i;
        end
        if (redirect_i && state_q == S_HOLD) begin
            buf_pc_d    = 32'h0;
            buf_instr_d = NOP_INSTR;
        end

        if (redirect_i) begin
            ifid_valid_d = 1'b0;
            ifid_pc_d    = 32'h0;
            ifid_instr_d = NOP_INSTR;
        end else if (ld_mem) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = req_pc_q;
            ifid_instr_d = imem_rdata_i;
        end else if (ld_buf) begin
            ifid_valid_d = 1'b1;
            ifid_pc_d    = buf_pc_q;
            ifid_instr_d = buf_instr_q;
        end else if (!stall_i) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
        end
    end

    // State, latches and IF/ID register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            req_pc_q     <= 32'h0;
            buf_pc_q     <= 32'h0;
            buf_instr_q  <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            req_pc_q     <= req_pc_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    assign ifid_valid_o = ifid_valid_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change 1 time unit after a rising edge,
// and outputs are sampled 1 time unit after that.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_i;
    logic [31:0] pc_next_o;
    logic        pc_write_en_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        ifid_valid_o;
    logic [31:0] ifid_pc_o;
    logic [31:0] ifid_instr_o;

    int n_checks = 0;
    int n_errors = 0;

    fetch_unit #(.NOP_INSTR(NOP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_i          (pc_i),
        .pc_next_o     (pc_next_o),
        .pc_write_en_o (pc_write_en_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .ifid_valid_o  (ifid_valid_o),
        .ifid_pc_o     (ifid_pc_o),
        .ifid_instr_o  (ifid_instr_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_ifid(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] instr);
        chk({tag, "_valid"}, {31'h0, ifid_valid_o}, {31'h0, v});
        chk({tag, "_pc"}, ifid_pc_o, pc);
        chk({tag, "_instr"}, ifid_instr_o, instr);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fetch: grant now, data the following cycle. Starts in S_REQ.
    task automatic do_fetch(input string tag, input logic [31:0] pc,
                            input logic [31:0] exp_next, input logic [31:0] data);
        pc_i = pc; imem_gnt_i = 1'b1; imem_rvalid_i = 1'b0;
        #1;
        chk({tag, "_req"}, {31'h0, imem_req_o}, 32'h1);
        chk({tag, "_addr"}, imem_addr_o, pc);
        chk({tag, "_we"}, {31'h0, pc_write_en_o}, 32'h1);
        chk({tag, "_pcnext"}, pc_next_o, exp_next);
        tick();
        pc_i = exp_next; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = data;
        #1;
        chk({tag, "_wait_req"}, {31'h0, imem_req_o}, 32'h0);
        chk({tag, "_wait_we"}, {31'h0, pc_write_en_o}, 32'h0);
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        chk_ifid({tag, "_ifid"}, 1'b1, pc, data);
    endtask

    initial begin
        rst_n = 1'b0; pc_i = 32'h0; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        imem_rdata_i = 32'h0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 32'h0;

        // Reset values
        #12;
        chk_ifid("rst", 1'b0, 32'h0, NOP);
        chk("rst_req", {31'h0, imem_req_o}, 32'h0);
        chk("rst_we", {31'h0, pc_write_en_o}, 32'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("rel_req", {31'h0, imem_req_o}, 32'h1);

        // Back-to-back zero-wait fetches
        do_fetch("f0", 32'h0000_0000, 32'h0000_0004, 32'h1111_0001);
        do_fetch("f4", 32'h0000_0004, 32'h0000_0008, 32'h1111_0002);
        do_fetch("f8", 32'h0000_0008, 32'h0000_000C, 32'h1111_0003);

        // Idle cycle without load: valid drops, NOP shown
        pc_i = 32'h0000_000C; imem_gnt_i = 1'b0;
        tick();
        chk("idle_valid", {31'h0, ifid_valid_o}, 32'h0);
        chk("idle_instr", ifid_instr_o, NOP);

        // Grant withheld three cycles
        pc_i = 32'h0000_0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("nogrant_addr", imem_addr_o, 32'h0000_0100);
            chk("nogrant_we", {31'h0, pc_write_en_o}, 32'h0);
            chk("nogrant_req", {31'h0, imem_req_o}, 32'h1);
            tick();
        end
        do_fetch("f100", 32'h0000_0100, 32'h0000_0104, 32'h1357_9BDF);

        // Stall while data returns at PC 0x20
        stall_i = 1'b1; pc_i = 32'h0000_0020; imem_gnt_i = 1'b1;
        #1;
        chk("st_pcnext", pc_next_o, 32'h0000_0024);
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF;
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        chk_ifid("st_hold", 1'b1, 32'h0000_0100, 32'h1357_9BDF);
        chk("st_hold_req", {31'h0, imem_req_o}, 32'h0);
        tick();
        chk_ifid("st_hold2", 1'b1, 32'h0000_0100, 32'h1357_9BDF);
        stall_i = 1'b0;
        tick();
        chk_ifid("st_rel", 1'b1, 32'h0000_0020, 32'hDEAD_BEEF);

        // Stray rvalid in S_REQ is ignored
        pc_i = 32'h0000_0040; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1;
        imem_rdata_i = 32'h0000_0055;
        tick();
        imem_rvalid_i = 1'b0;
        chk_ifid("stray_req", 1'b0, 32'h0000_0020, NOP);

        // Redirect while waiting: drain the in-flight response
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0203;
        #1;
        chk("rd_pcnext", pc_next_o, 32'h0000_0200);
        chk("rd_we", {31'h0, pc_write_en_o}, 32'h1);
        chk("rd_req", {31'h0, imem_req_o}, 32'h0);
        tick();
        redirect_i = 1'b0; pc_i = 32'h0000_0200;
        #1;
        chk_ifid("rd_flush", 1'b0, 32'h0, NOP);
        chk("drain_req", {31'h0, imem_req_o}, 32'h0);
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hBAD0_BAD0;
        tick();
        imem_rvalid_i = 1'b0;
        #1;
        chk_ifid("drain_drop", 1'b0, 32'h0, NOP);
        chk("drain_next_req", {31'h0, imem_req_o}, 32'h1);
        chk("drain_next_addr", imem_addr_o, 32'h0000_0200);

        // Redirect in S_HOLD under stall: flush wins
        imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h2222_2222; stall_i = 1'b1;
        tick();
        imem_rvalid_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 32'h0000_0400;
        #1;
        chk("hold_rd_pcnext", pc_next_o, 32'h0000_0400);
        tick();
        redirect_i = 1'b0; stall_i = 1'b0; pc_i = 32'h0000_0400;
        #1;
        chk_ifid("hold_flush", 1'b0, 32'h0, NOP);
        chk("hold_rd_req", {31'h0, imem_req_o}, 32'h1);

        // PC wrap at the top of the address space
        do_fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0000, 32'hCAFE_F00D);

        // Asynchronous reset while waiting, then a stray rvalid after release
        stall_i = 1'b1; pc_i = 32'h0000_0010; imem_gnt_i = 1'b1;
        tick();
        imem_gnt_i = 1'b0;
        #1;
        chk("pre_rst_valid", {31'h0, ifid_valid_o}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk_ifid("arst", 1'b0, 32'h0, NOP);
        chk("arst_req", {31'h0, imem_req_o}, 32'h0);
        chk("arst_we", {31'h0, pc_write_en_o}, 32'h0);
        tick();
        rst_n = 1'b1; stall_i = 1'b0; imem_rvalid_i = 1'b1; imem_rdata_i = 32'h7777_7777;
        #1;
        chk("post_rst_req", {31'h0, imem_req_o}, 32'h1);
        tick();
        imem_rvalid_i = 1'b0;
        chk_ifid("post_rst_stray", 1'b0, 32'h0, NOP);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0013 (addi x0,x0,0), SHALL be the instruction presented on ifid_instr_o whenever IF/ID holds no valid instruction.
REQ-002 clk  input  1  clock; all state SHALL update on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pc_i  input  32  current PC from the PC register.
REQ-005 pc_next_o  output  32  next PC value to the PC register.
REQ-006 pc_write_en_o  output  1  PC register update enable.
REQ-007 imem_req_o  output  1  instruction-memory request valid.
REQ-008 imem_addr_o  output  32  instruction-memory request address.
REQ-009 imem_gnt_i  input  1  request accepted this cycle.
REQ-010 imem_rvalid_i  input  1  read data valid.
REQ-011 imem_rdata_i  input  32  read data (instruction word).
REQ-012 stall_i  input  1  decode stall; IF/ID SHALL hold.
REQ-013 redirect_i  input  1  branch/jump/flush redirect.
REQ-014 redirect_pc_i  input  32  redirect target.
REQ-015 ifid_valid_o, ifid_pc_o[31:0], ifid_instr_o[31:0]  outputs  IF/ID pipeline register.

Function
REQ-016 FSM SHALL have states REQ, WAIT, HOLD, DRAIN, with at most one outstanding memory request.
REQ-017 REQ: imem_req_o=1 and imem_addr_o={pc_i[31:2],2'b00} unless redirect_i=1, in which case imem_req_o=0.
REQ-018 REQ with imem_gnt_i=1 and redirect_i=0: pc_next_o=pc_i+4 (mod 2^32, 0xFFFF_FFFC wraps to 0), pc_write_en_o=1, request PC latched internally, next state WAIT.
REQ-019 REQ with imem_gnt_i=0: stay REQ; pc_write_en_o=0, so imem_addr_o stays stable while request is pending.
REQ-020 WAIT, imem_rvalid_i=1, stall_i=0, redirect_i=0: IF/ID loads {1, latched PC, imem_rdata_i}; next state REQ.
REQ-021 WAIT, imem_rvalid_i=1, stall_i=1, redirect_i=0: response captured into a one-entry buffer; next state HOLD; IF/ID unchanged.
REQ-022 HOLD with stall_i=0: IF/ID loads the buffered PC and instruction, valid=1; next state REQ.
REQ-023 Any state, redirect_i=1: pc_next_o={redirect_pc_i[31:2],2'b00}, pc_write_en_o=1; IF/ID flushed next edge to {0, 32'h0, NOP_INSTR}, even if stall_i=1 (flush dominates stall).
REQ-024 Redirect next state: REQ→REQ (any coincident grant discarded, imem_req_o already 0); WAIT without rvalid→DRAIN; WAIT with rvalid→REQ (data dropped); HOLD→REQ (buffer discarded); DRAIN→DRAIN, or REQ if rvalid.
REQ-025 DRAIN: imem_req_o=0; on imem_rvalid_i=1 the data SHALL be discarded and the next state SHALL be REQ.
REQ-026 With stall_i=0 and no load in a cycle, ifid_valid_o SHALL drop to 0 next edge and ifid_instr_o SHALL become NOP_INSTR; with stall_i=1 all IF/ID fields SHALL hold.
REQ-027 imem_rvalid_i in REQ or HOLD SHALL be ignored; imem_gnt_i outside REQ SHALL be ignored.
REQ-028 Peak throughput SHALL be one instruction per two cycles (grant, then rvalid in the following cycle).

Reset
REQ-029 rst_n low SHALL immediately force state REQ, ifid_valid_o=0, ifid_pc_o=0, ifid_instr_o=NOP_INSTR, clear the buffer, and clear the latched PC.
REQ-030 During reset, pc_write_en_o=0 and imem_req_o=0; requests SHALL start on the first edge after deassertion.
REQ-031 Reset asserted mid-request SHALL abandon the outstanding transaction; a late rvalid SHALL be ignored (REQ-027).

Verification
REQ-032 Zero-wait memory, pc_i 0→4→8: IF/ID shows PCs 0,4,8 every second cycle with matching rdata; pc_next_o=4,8,12.
REQ-033 Grant withheld 3 cycles at pc_i=0x100: imem_addr_o stays 0x100, pc_write_en_o=0 throughout, one write of 0x104 on grant.
REQ-034 stall_i=1 while rvalid returns 0xDEADBEEF at PC 0x20: IF/ID unchanged; after stall drops, IF/ID={1,0x20,0xDEADBEEF} next edge.
REQ-035 redirect_i=1 to 0x203 in WAIT: pc_next_o=0x200, state DRAIN; following rvalid discarded; next request addr 0x200; ifid_valid_o=0.
REQ-036 pc_i=0xFFFF_FFFC granted: pc_next_o=0x0000_0000.
REQ-037 rst_n pulsed low in WAIT: outputs at reset values asynchronously; stray rvalid after release leaves ifid_valid_o=0.
